// File: rtl/mac_pkg.sv
// -----------------------------------------------------------------------------
// mac_pkg
// Shared constants and helper functions for the mac_pipe_acc datapath.
//   sum_width(inWidth, concat) : width of the registered lane-sum
//                                (2*inWidth + clog2(concat)).
//   acc_max(accWidth) / acc_min(accWidth) : saturation limits of a signed
//                                accumulator of accWidth bits, returned in a
//                                WIDE_W-bit container. The caller slices the
//                                low accWidth bits.
// Accumulators wider than WIDE_W bits are not supported by these helpers.
// -----------------------------------------------------------------------------
package mac_pkg;

    localparam int WIDE_W = 128;

    // The lane sum needs two product widths plus one bit per doubling of lanes
    function automatic int sum_width(input int inWidth, input int concat);
        return 2 * inWidth + $clog2(concat);
    endfunction

    // Largest positive value of a signed accWidth-bit number: 0111...1
    function automatic logic signed [WIDE_W-1:0] acc_max(input int accWidth);
        logic signed [WIDE_W-1:0] v;
        v = '0;
        for (int i = 0; i < accWidth - 1; i++) begin
            v[i] = 1'b1;
        end
        return v;
    endfunction

    // Most negative value of a signed accWidth-bit number, sign-extended to
    // WIDE_W bits so that the low accWidth bits read 1000...0
    function automatic logic signed [WIDE_W-1:0] acc_min(input int accWidth);
        logic signed [WIDE_W-1:0] v;
        v = '1;
        for (int i = 0; i < accWidth - 1; i++) begin
            v[i] = 1'b0;
        end
        return v;
    endfunction

endpackage

// File: rtl/mac_lane_tree.sv
// -----------------------------------------------------------------------------
// mac_lane_tree
// Stages 1 and 2 of the dot-product pipeline: CONCAT signed lane products are
// registered (stage P), then their sign-extended sum is registered (stage S).
// Both stages load only while en_i is high and hold otherwise.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   en_i      : pipeline advance enable
//   valid_i   : input beat valid (already qualified by the caller's ready)
//   last_i    : input beat closes the current accumulation
//   a_i, b_i  : packed signed lanes, lane k at [k*IN_WIDTH +: IN_WIDTH]
//   sum_o     : registered lane sum (signed, SUM_W bits)
//   valid_o   : stage S holds a beat
//   last_o    : stage S beat is the last of its accumulation
// -----------------------------------------------------------------------------
module mac_lane_tree
    import mac_pkg::*;
#(
    parameter int IN_WIDTH = 16,
    parameter int CONCAT   = 4,
    localparam int SUM_W   = sum_width(IN_WIDTH, CONCAT)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en_i,
    input  logic                       valid_i,
    input  logic                       last_i,
    input  logic [CONCAT*IN_WIDTH-1:0] a_i,
    input  logic [CONCAT*IN_WIDTH-1:0] b_i,
    output logic [SUM_W-1:0]           sum_o,
    output logic                       valid_o,
    output logic                       last_o
);

    localparam int PROD_W = 2 * IN_WIDTH;

    logic signed [PROD_W-1:0] prod_d [CONCAT];
    logic signed [PROD_W-1:0] prod_q [CONCAT];
    logic                     pValid_q;
    logic                     pLast_q;

    logic signed [SUM_W-1:0]  sum_d;
    logic signed [SUM_W-1:0]  sum_q;
    logic                     sValid_q;
    logic                     sLast_q;

    // Each lane is widened to the full product width before multiplying so
    // the signed product is exact
    always_comb begin
        for (int k = 0; k < CONCAT; k++) begin
            prod_d[k] = PROD_W'($signed(a_i[k*IN_WIDTH +: IN_WIDTH]))
                      * PROD_W'($signed(b_i[k*IN_WIDTH +: IN_WIDTH]));
        end
    end

    // Stage P: product registers with their valid/last tags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < CONCAT; k++) begin
                prod_q[k] <= '0;
            end
            pValid_q <= 1'b0;
            pLast_q  <= 1'b0;
        end else if (en_i) begin
            prod_q   <= prod_d;
            pValid_q <= valid_i;
            pLast_q  <= valid_i && last_i;
        end
    end

    // Adder tree over the registered products; every product is sign-extended
    // to the sum width first, which is wide enough that the sum never overflows
    always_comb begin
        sum_d = '0;
        for (int k = 0; k < CONCAT; k++) begin
            sum_d = sum_d + SUM_W'(prod_q[k]);
        end
    end

    // Stage S: registered lane sum with its valid/last tags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q    <= '0;
            sValid_q <= 1'b0;
            sLast_q  <= 1'b0;
        end else if (en_i) begin
            sum_q    <= sum_d;
            sValid_q <= pValid_q;
            sLast_q  <= pLast_q;
        end
    end

    assign sum_o   = sum_q;
    assign valid_o = sValid_q;
    assign last_o  = sLast_q;

endmodule

// File: rtl/mac_pipe_acc.sv
// -----------------------------------------------------------------------------
// mac_pipe_acc
// Pipelined dot-product accumulator. Each accepted beat carries CONCAT signed
// lane pairs; their products are summed (mac_lane_tree) and accumulated until
// a beat marked in_last reaches the accumulator, at which point the total, the
// beat count and an overflow flag are presented on a valid/ready output.
// The whole pipeline freezes while a result is waiting for out_ready.
//
// Build option:
//   MAC_PIPE_ACC_SAT_EN defined   : accumulator additions saturate to the
//                                   signed ACC_WIDTH range; out_ovf reports
//                                   that saturation happened.
//   MAC_PIPE_ACC_SAT_EN undefined : accumulator wraps; out_ovf reports that a
//                                   signed overflow happened.
//   In both cases the overflow bit is sticky within one accumulation.
//
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   in_1, in_2     : packed signed lane operands
//   in_valid       : input beat valid
//   in_last        : beat closes the current accumulation
//   in_ready       : a beat is accepted this cycle when in_valid is also high
//   out            : accumulated dot product (signed)
//   out_beats      : number of beats in this result (saturating)
//   out_ovf        : overflow/saturation occurred in this result
//   out_valid      : result valid
//   out_ready      : downstream accepts the result
// -----------------------------------------------------------------------------
module mac_pipe_acc
    import mac_pkg::*;
#(
    parameter int IN_WIDTH  = 16,
    parameter int CONCAT    = 4,
    parameter int ACC_WIDTH = 40,
    parameter int CNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [CONCAT*IN_WIDTH-1:0] in_1,
    input  logic [CONCAT*IN_WIDTH-1:0] in_2,
    input  logic                       in_valid,
    input  logic                       in_last,
    output logic                       in_ready,
    output logic [ACC_WIDTH-1:0]       out,
    output logic [CNT_WIDTH-1:0]       out_beats,
    output logic                       out_ovf,
    output logic                       out_valid,
    input  logic                       out_ready
);

    localparam int SUM_W = sum_width(IN_WIDTH, CONCAT);
    localparam int WIDE_ACC = ACC_WIDTH + 1;

`ifdef MAC_PIPE_ACC_SAT_EN
    localparam logic signed [WIDE_W-1:0]    ACC_MAX_WIDE = acc_max(ACC_WIDTH);
    localparam logic signed [WIDE_W-1:0]    ACC_MIN_WIDE = acc_min(ACC_WIDTH);
    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = ACC_MAX_WIDE[ACC_WIDTH-1:0];
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = ACC_MIN_WIDE[ACC_WIDTH-1:0];
`endif

    logic                 adv;
    logic [SUM_W-1:0]     sSum;
    logic                 sValid;
    logic                 sLast;

    logic signed [ACC_WIDTH-1:0] accSum_q,    accSum_d;
    logic [CNT_WIDTH-1:0]        beatCnt_q,   beatCnt_d;
    logic                        ovfFlag_q,   ovfFlag_d;
    logic                        firstBeat_q, firstBeat_d;
    logic signed [ACC_WIDTH-1:0] outAcc_q,    outAcc_d;
    logic [CNT_WIDTH-1:0]        outBeats_q,  outBeats_d;
    logic                        outOvf_q,    outOvf_d;
    logic                        outValid_q,  outValid_d;

    logic signed [ACC_WIDTH-1:0] sumExt;
    logic signed [ACC_WIDTH-1:0] accBase;
    logic signed [ACC_WIDTH:0]   accWide;
    logic                        addOvf;
    logic signed [ACC_WIDTH-1:0] accNew;
    logic                        ovfNew;
    logic [CNT_WIDTH-1:0]        cntNew;

    // The pipeline only moves when the output register is free or being drained
    assign adv      = !(outValid_q && !out_ready);
    assign in_ready = adv;

    mac_lane_tree #(
        .IN_WIDTH (IN_WIDTH),
        .CONCAT   (CONCAT)
    ) u_lane_tree (
        .clk     (clk),
        .rst     (rst),
        .en_i    (adv),
        .valid_i (in_valid),
        .last_i  (in_last),
        .a_i     (in_1),
        .b_i     (in_2),
        .sum_o   (sSum),
        .valid_o (sValid),
        .last_o  (sLast)
    );

    // Accumulator arithmetic. The addition is done one bit wider so that a
    // signed overflow shows up as a disagreement between the top two bits; the
    // top bit then carries the true sign for choosing the saturation rail.
    // On a first beat the base is zero, so no overflow is possible there.
    always_comb begin
        sumExt  = ACC_WIDTH'($signed(sSum));
        accBase = firstBeat_q ? '0 : accSum_q;
        accWide = WIDE_ACC'(accBase) + WIDE_ACC'(sumExt);
        addOvf  = accWide[ACC_WIDTH] ^ accWide[ACC_WIDTH-1];
`ifdef MAC_PIPE_ACC_SAT_EN
        if (addOvf) begin
            accNew = accWide[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
        end else begin
            accNew = accWide[ACC_WIDTH-1:0];
        end
`else
        accNew = accWide[ACC_WIDTH-1:0];
`endif
        ovfNew = (!firstBeat_q && ovfFlag_q) || addOvf;
        if (firstBeat_q) begin
            cntNew = CNT_WIDTH'(1);
        end else if (&beatCnt_q) begin
            cntNew = beatCnt_q;
        end else begin
            cntNew = beatCnt_q + CNT_WIDTH'(1);
        end
    end

    // Next-state for stage A and the output register. When advancing, a
    // held result is considered consumed; a new last beat reloads it on the
    // same edge, otherwise out_valid drops while the data stays put.
    always_comb begin
        accSum_d    = accSum_q;
        beatCnt_d   = beatCnt_q;
        ovfFlag_d   = ovfFlag_q;
        firstBeat_d = firstBeat_q;
        outAcc_d    = outAcc_q;
        outBeats_d  = outBeats_q;
        outOvf_d    = outOvf_q;
        outValid_d  = outValid_q;
        if (adv) begin
            outValid_d = 1'b0;
            if (sValid) begin
                accSum_d    = accNew;
                beatCnt_d   = cntNew;
                ovfFlag_d   = ovfNew;
                firstBeat_d = sLast;
                if (sLast) begin
                    outAcc_d   = accNew;
                    outBeats_d = cntNew;
                    outOvf_d   = ovfNew;
                    outValid_d = 1'b1;
                end
            end
        end
    end

    // Stage A and output registers; reset discards any partial accumulation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            accSum_q    <= '0;
            beatCnt_q   <= '0;
            ovfFlag_q   <= 1'b0;
            firstBeat_q <= 1'b1;
            outAcc_q    <= '0;
            outBeats_q  <= '0;
            outOvf_q    <= 1'b0;
            outValid_q  <= 1'b0;
        end else begin
            accSum_q    <= accSum_d;
            beatCnt_q   <= beatCnt_d;
            ovfFlag_q   <= ovfFlag_d;
            firstBeat_q <= firstBeat_d;
            outAcc_q    <= outAcc_d;
            outBeats_q  <= outBeats_d;
            outOvf_q    <= outOvf_d;
            outValid_q  <= outValid_d;
        end
    end

    assign out       = outAcc_q;
    assign out_beats = outBeats_q;
    assign out_ovf   = outOvf_q;
    assign out_valid = outValid_q;

endmodule

// File: tb/tb_mac_pipe_acc.sv
// -----------------------------------------------------------------------------
// tb_mac_pipe_acc
// Self-checking bench for mac_pipe_acc (IN_WIDTH=16, CONCAT=4, ACC_WIDTH=34).
// A reference model accumulates every accepted beat with plain integer
// arithmetic and queues the expected results; observed results are queued as
// they are handed off. Honours MAC_PIPE_ACC_SAT_EN like the design.
// -----------------------------------------------------------------------------
module tb_mac_pipe_acc;

    localparam int IN_W  = 16;
    localparam int LANES = 4;
    localparam int ACC_W = 34;
    localparam int CNT_W = 16;

    localparam longint ACC_MAX_L = (longint'(1) << (ACC_W - 1)) - 1;
    localparam longint ACC_MIN_L = -(longint'(1) << (ACC_W - 1));
    localparam longint ACC_MOD_L = longint'(1) << ACC_W;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [LANES*IN_W-1:0]   in1;
    logic [LANES*IN_W-1:0]   in2;
    logic                    inValid;
    logic                    inLast;
    logic                    inReady;
    logic [ACC_W-1:0]        outAcc;
    logic [CNT_W-1:0]        outBeats;
    logic                    outOvf;
    logic                    outValid;
    logic                    outReady;

    int checks = 0;
    int errors = 0;

    // Reference model state
    longint mAcc;
    int     mCnt;
    bit     mOvf;
    bit     mFirst;
    longint expOut[$];
    int     expBeats[$];
    bit     expOvf[$];
    longint gotOut[$];
    int     gotBeats[$];
    bit     gotOvf[$];

    mac_pipe_acc #(
        .IN_WIDTH  (IN_W),
        .CONCAT    (LANES),
        .ACC_WIDTH (ACC_W),
        .CNT_WIDTH (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_1      (in1),
        .in_2      (in2),
        .in_valid  (inValid),
        .in_last   (inLast),
        .in_ready  (inReady),
        .out       (outAcc),
        .out_beats (outBeats),
        .out_ovf   (outOvf),
        .out_valid (outValid),
        .out_ready (outReady)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [LANES*IN_W-1:0] packLanes(input int l0, input int l1,
                                                        input int l2, input int l3);
        logic [LANES*IN_W-1:0] v;
        int t[4];
        t = '{l0, l1, l2, l3};
        for (int k = 0; k < LANES; k++) begin
            v[k*IN_W +: IN_W] = t[k][IN_W-1:0];
        end
        return v;
    endfunction

    // Dot product of one beat, then accumulate with the overflow policy
    task automatic modelBeat(input logic [LANES*IN_W-1:0] a, input logic [LANES*IN_W-1:0] b,
                             input logic last);
        longint s;
        longint t;
        logic signed [IN_W-1:0] la;
        logic signed [IN_W-1:0] lb;
        s = 0;
        for (int k = 0; k < LANES; k++) begin
            la = a[k*IN_W +: IN_W];
            lb = b[k*IN_W +: IN_W];
            s += longint'(la) * longint'(lb);
        end
        if (mFirst) begin
            t = s;
            mCnt = 1;
            mOvf = 1'b0;
        end else begin
            t = mAcc + s;
            mCnt = (mCnt == (1 << CNT_W) - 1) ? mCnt : mCnt + 1;
        end
        if (t > ACC_MAX_L || t < ACC_MIN_L) begin
            mOvf = 1'b1;
`ifdef MAC_PIPE_ACC_SAT_EN
            t = (t > ACC_MAX_L) ? ACC_MAX_L : ACC_MIN_L;
`else
            while (t > ACC_MAX_L) t -= ACC_MOD_L;
            while (t < ACC_MIN_L) t += ACC_MOD_L;
`endif
        end
        mAcc = t;
        mFirst = last;
        if (last) begin
            expOut.push_back(mAcc);
            expBeats.push_back(mCnt);
            expOvf.push_back(mOvf);
        end
    endtask

    task automatic clearQueues();
        expOut.delete();
        expBeats.delete();
        expOvf.delete();
        gotOut.delete();
        gotBeats.delete();
        gotOvf.delete();
    endtask

    task automatic resetModel();
        mAcc = 0;
        mCnt = 0;
        mOvf = 1'b0;
        mFirst = 1'b1;
        clearQueues();
    endtask

    // One clock cycle: called just after a negedge with inputs already driven
    task automatic tick();
        #1;
        if (inValid && inReady) modelBeat(in1, in2, inLast);
        if (outValid && outReady) begin
            gotOut.push_back(longint'($signed(outAcc)));
            gotBeats.push_back(int'(outBeats));
            gotOvf.push_back(outOvf);
        end
        @(negedge clk);
    endtask

    task automatic drain(output bit ok);
        inValid = 1'b0;
        outReady = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (i >= 4 && gotOut.size() == expOut.size()) break;
            tick();
        end
        ok = (gotOut.size() == expOut.size());
    endtask

    task automatic test_reset();
        bit ok;
        rst = 1'b1;
        inValid = 1'b0;
        inLast = 1'b0;
        in1 = '0;
        in2 = '0;
        outReady = 1'b1;
        resetModel();
        @(negedge clk);
        @(negedge clk);
        checks++; if (outAcc !== '0) begin errors++; $display("[TB] FAIL reset_out got %0d expected 0", outAcc); end
        checks++; if (outBeats !== '0) begin errors++; $display("[TB] FAIL reset_beats got %0d expected 0", outBeats); end
        checks++; if (outOvf !== 1'b0) begin errors++; $display("[TB] FAIL reset_ovf got %b expected 0", outOvf); end
        checks++; if (outValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b expected 0", outValid); end
        checks++; if (inReady !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready got %b expected 1", inReady); end
        rst = 1'b0;
        @(negedge clk);
        // Two non-last beats fully reach the accumulator, then reset mid-sum
        for (int i = 0; i < 2; i++) begin
            inValid = 1'b1;
            inLast = 1'b0;
            in1 = packLanes(100 + i, 7, -9, 3);
            in2 = packLanes(5, 5, 5, 5);
            tick();
        end
        inValid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        #2 rst = 1'b1;
        #2;
        checks++; if (outValid !== 1'b0) begin errors++; $display("[TB] FAIL midreset_valid got %b expected 0", outValid); end
        checks++; if (outAcc !== '0) begin errors++; $display("[TB] FAIL midreset_out got %0d expected 0", outAcc); end
        rst = 1'b0;
        resetModel();
        @(negedge clk);
        inValid = 1'b1;
        inLast = 1'b1;
        in1 = packLanes(1, 1, 1, 1);
        in2 = packLanes(1, 1, 1, 1);
        tick();
        drain(ok);
        checks++; if (!ok || gotOut.size() != 1) begin errors++; $display("[TB] FAIL postreset_count got %0d expected 1", gotOut.size()); end
        if (gotOut.size() == 1) begin
            checks++; if (gotOut[0] !== 64'sd4) begin errors++; $display("[TB] FAIL postreset_out got %0d expected 4", gotOut[0]); end
            checks++; if (gotBeats[0] !== 1) begin errors++; $display("[TB] FAIL postreset_beats got %0d expected 1", gotBeats[0]); end
        end
        clearQueues();
    endtask

    task automatic test_basic_latency();
        clearQueues();
        outReady = 1'b1;
        in1 = packLanes(1, 2, 3, 4);
        in2 = packLanes(5, 6, 7, 8);
        inValid = 1'b1;
        inLast = 1'b1;
        #1;
        checks++; if (inReady !== 1'b1) begin errors++; $display("[TB] FAIL lat_in_ready got %b expected 1", inReady); end
        modelBeat(in1, in2, inLast);
        // Accept edge counts as the first of the three pipeline edges
        for (int e = 1; e <= 3; e++) begin
            @(negedge clk);
            inValid = 1'b0;
            #1;
            checks++;
            if (outValid !== (e == 3)) begin
                errors++;
                $display("[TB] FAIL lat_valid_edge%0d got %b expected %b", e, outValid, (e == 3));
            end
        end
        checks++; if ($signed(outAcc) !== 34'sd70) begin errors++; $display("[TB] FAIL lat_out got %0d expected 70", $signed(outAcc)); end
        checks++; if (longint'($signed(outAcc)) !== expOut[0]) begin errors++; $display("[TB] FAIL lat_out_model got %0d expected %0d", $signed(outAcc), expOut[0]); end
        checks++; if (outBeats !== 16'd1) begin errors++; $display("[TB] FAIL lat_beats got %0d expected 1", outBeats); end
        @(negedge clk);
        #1;
        checks++; if (outValid !== 1'b0) begin errors++; $display("[TB] FAIL lat_drop got %b expected 0", outValid); end
        @(negedge clk);
        clearQueues();
    endtask

    task automatic test_bubbles();
        bit ok;
        clearQueues();
        outReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            inValid = 1'b1;
            inLast = (i == 2);
            in1 = packLanes(-3, -3, -3, -3);
            in2 = packLanes(2, 2, 2, 2);
            tick();
            inValid = 1'b0;
            for (int j = 0; j <= i; j++) tick();
        end
        drain(ok);
        checks++; if (!ok || gotOut.size() != 1) begin errors++; $display("[TB] FAIL bubble_count got %0d expected 1", gotOut.size()); end
        if (gotOut.size() == 1 && expOut.size() == 1) begin
            checks++; if (gotOut[0] !== -64'sd72) begin errors++; $display("[TB] FAIL bubble_out got %0d expected -72", gotOut[0]); end
            checks++; if (gotBeats[0] !== 3) begin errors++; $display("[TB] FAIL bubble_beats got %0d expected 3", gotBeats[0]); end
            checks++; if (gotOvf[0] !== 1'b0) begin errors++; $display("[TB] FAIL bubble_ovf got %b expected 0", gotOvf[0]); end
            checks++; if (gotOut[0] !== expOut[0]) begin errors++; $display("[TB] FAIL bubble_model got %0d expected %0d", gotOut[0], expOut[0]); end
        end
        clearQueues();
    endtask

    task automatic test_backpressure();
        logic [LANES*IN_W-1:0] bA[3];
        logic [LANES*IN_W-1:0] bB[3];
        logic [ACC_W-1:0]      heldVal;
        bit                    seen;
        bit                    accepted;
        int                    idx;
        int                    holdCnt;
        clearQueues();
        for (int i = 0; i < 3; i++) begin
            bA[i] = {$urandom, $urandom};
            bB[i] = {$urandom, $urandom};
        end
        inValid = 1'b1;
        inLast = 1'b1;
        in1 = {$urandom, $urandom};
        in2 = {$urandom, $urandom};
        outReady = 1'b0;
        tick();
        idx = 0;
        holdCnt = 0;
        seen = 1'b0;
        heldVal = '0;
        for (int cyc = 0; cyc < 80; cyc++) begin
            if (idx < 3) begin
                inValid = 1'b1;
                in1 = bA[idx];
                in2 = bB[idx];
                inLast = (idx == 2);
            end else begin
                inValid = 1'b0;
            end
            outReady = (holdCnt >= 5);
            #1;
            if (outValid && !outReady) begin
                checks++; if (inReady !== 1'b0) begin errors++; $display("[TB] FAIL bp_in_ready got %b expected 0", inReady); end
                if (seen) begin
                    checks++; if (outAcc !== heldVal) begin errors++; $display("[TB] FAIL bp_stable got %0d expected %0d", outAcc, heldVal); end
                end else begin
                    heldVal = outAcc;
                    seen = 1'b1;
                end
                holdCnt++;
            end
            accepted = inValid && inReady;
            tick();
            if (accepted) idx++;
            if (idx == 3 && gotOut.size() == 2) break;
        end
        checks++; if (holdCnt != 5) begin errors++; $display("[TB] FAIL bp_hold_cycles got %0d expected 5", holdCnt); end
        checks++; if (gotOut.size() != 2 || expOut.size() != 2) begin errors++; $display("[TB] FAIL bp_count got %0d expected %0d", gotOut.size(), expOut.size()); end
        if (gotOut.size() == 2 && expOut.size() == 2) begin
            checks++; if (gotOut[0] !== longint'($signed(heldVal))) begin errors++; $display("[TB] FAIL bp_first_held got %0d expected %0d", gotOut[0], $signed(heldVal)); end
            for (int i = 0; i < 2; i++) begin
                checks++; if (gotOut[i] !== expOut[i]) begin errors++; $display("[TB] FAIL bp_out%0d got %0d expected %0d", i, gotOut[i], expOut[i]); end
                checks++; if (gotBeats[i] !== expBeats[i]) begin errors++; $display("[TB] FAIL bp_beats%0d got %0d expected %0d", i, gotBeats[i], expBeats[i]); end
            end
        end
        outReady = 1'b1;
        clearQueues();
    endtask

    task automatic test_back_to_back();
        longint seenVal[$];
        int     seenCyc[$];
        clearQueues();
        outReady = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (c < 4) begin
                inValid = 1'b1;
                inLast = 1'b1;
                in1 = packLanes(c + 1, 0, 0, 0);
                in2 = packLanes(1, 0, 0, 0);
            end else begin
                inValid = 1'b0;
            end
            #1;
            if (outValid) begin
                seenVal.push_back(longint'($signed(outAcc)));
                seenCyc.push_back(c);
            end
            tick();
        end
        checks++; if (seenVal.size() != 4) begin errors++; $display("[TB] FAIL b2b_count got %0d expected 4", seenVal.size()); end
        if (seenVal.size() == 4) begin
            checks++; if (seenCyc[0] != 3) begin errors++; $display("[TB] FAIL b2b_first_cycle got %0d expected 3", seenCyc[0]); end
            for (int i = 0; i < 4; i++) begin
                checks++; if (seenVal[i] !== longint'(i + 1)) begin errors++; $display("[TB] FAIL b2b_out%0d got %0d expected %0d", i, seenVal[i], i + 1); end
                checks++; if (seenCyc[i] != seenCyc[0] + i) begin errors++; $display("[TB] FAIL b2b_cycle%0d got %0d expected %0d", i, seenCyc[i], seenCyc[0] + i); end
            end
        end
        clearQueues();
    endtask

    task automatic test_overflow();
        bit     ok;
        longint wantOut;
`ifdef MAC_PIPE_ACC_SAT_EN
        wantOut = 64'sd8589934591;
`else
        wantOut = 64'sd8587313192;
`endif
        clearQueues();
        outReady = 1'b1;
        for (int i = 0; i < 10; i++) begin
            inValid = 1'b1;
            inLast = (i == 9);
            in1 = packLanes(32767, 32767, 32767, 32767);
            in2 = packLanes(32767, 32767, 32767, 32767);
            tick();
        end
        drain(ok);
        checks++; if (!ok || gotOut.size() != 1) begin errors++; $display("[TB] FAIL ovf_count got %0d expected 1", gotOut.size()); end
        if (gotOut.size() == 1 && expOut.size() == 1) begin
            checks++; if (gotOut[0] !== wantOut) begin errors++; $display("[TB] FAIL ovf_out got %0d expected %0d", gotOut[0], wantOut); end
            checks++; if (gotOvf[0] !== 1'b1) begin errors++; $display("[TB] FAIL ovf_flag got %b expected 1", gotOvf[0]); end
            checks++; if (gotBeats[0] !== 10) begin errors++; $display("[TB] FAIL ovf_beats got %0d expected 10", gotBeats[0]); end
            checks++; if (gotOut[0] !== expOut[0]) begin errors++; $display("[TB] FAIL ovf_model got %0d expected %0d", gotOut[0], expOut[0]); end
        end
        clearQueues();
        for (int i = 0; i < 2; i++) begin
            inValid = 1'b1;
            inLast = (i == 1);
            in1 = packLanes($urandom_range(200) - 100, $urandom_range(200) - 100,
                            $urandom_range(200) - 100, $urandom_range(200) - 100);
            in2 = packLanes($urandom_range(200) - 100, $urandom_range(200) - 100,
                            $urandom_range(200) - 100, $urandom_range(200) - 100);
            tick();
        end
        drain(ok);
        checks++; if (!ok || gotOut.size() != 1) begin errors++; $display("[TB] FAIL ovf_next_count got %0d expected 1", gotOut.size()); end
        if (gotOut.size() == 1 && expOut.size() == 1) begin
            checks++; if (gotOvf[0] !== 1'b0) begin errors++; $display("[TB] FAIL ovf_next_flag got %b expected 0", gotOvf[0]); end
            checks++; if (gotOut[0] !== expOut[0]) begin errors++; $display("[TB] FAIL ovf_next_out got %0d expected %0d", gotOut[0], expOut[0]); end
        end
        clearQueues();
    endtask

    task automatic test_random();
        bit ok;
        bit accepted;
        int len;
        int n;
        clearQueues();
        for (int a = 0; a < 10; a++) begin
            len = $urandom_range(1, 5);
            for (int b = 0; b < len; b++) begin
                inValid = 1'b1;
                inLast = (b == len - 1);
                in1 = {$urandom, $urandom};
                in2 = {$urandom, $urandom};
                accepted = 1'b0;
                for (int w = 0; w < 50 && !accepted; w++) begin
                    outReady = ($urandom_range(0, 3) != 0);
                    #1;
                    accepted = inReady;
                    tick();
                end
                if (!accepted) begin
                    checks++; errors++;
                    $display("[TB] FAIL rand_accept_timeout got 0 expected 1");
                end
                if ($urandom_range(0, 2) == 0) begin
                    inValid = 1'b0;
                    outReady = $urandom_range(0, 1);
                    tick();
                end
            end
        end
        drain(ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL rand_count got %0d expected %0d", gotOut.size(), expOut.size()); end
        n = (gotOut.size() < expOut.size()) ? gotOut.size() : expOut.size();
        for (int i = 0; i < n; i++) begin
            checks++; if (gotOut[i] !== expOut[i]) begin errors++; $display("[TB] FAIL rand_out%0d got %0d expected %0d", i, gotOut[i], expOut[i]); end
            checks++; if (gotBeats[i] !== expBeats[i]) begin errors++; $display("[TB] FAIL rand_beats%0d got %0d expected %0d", i, gotBeats[i], expBeats[i]); end
            checks++; if (gotOvf[i] !== expOvf[i]) begin errors++; $display("[TB] FAIL rand_ovf%0d got %b expected %b", i, gotOvf[i], expOvf[i]); end
        end
        clearQueues();
    endtask

    initial begin
        $display("[TB] mac_pipe_acc bench start");
        test_reset();
        test_basic_latency();
        test_bubbles();
        test_backpressure();
        test_back_to_back();
        test_overflow();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
